fpu_issue_scoreboard: RTL and testbench

Parametrised issue stage for the FPU opcode group (opcode 010001). It decodes incoming FPU instructions and tracks in-flight destinations with a per-register busy scoreboard. It also reserves the single shared writeback port per cycle and stalls on RAW, WAW and writeback-port hazards. The block sits between instruction decode and the pipelined FPU datapath, which never back-pressures.

---
 rtl/fpu_issue_scoreboard.sv | 135 +++++++++++++
 tb/tb_fpu_issue_scoreboard.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_scoreboard.sv
// fpu_issue_scoreboard: FPU issue stage with a register busy scoreboard and a shared writeback-port slot ring.
module fpu_issue_scoreboard #(
   parameter int REG_W      = 5,
   parameter int LAT_ADD    = 3,
   parameter int LAT_MUL    = 2,
   parameter int LAT_INV    = 6,
   parameter int LAT_SQRT   = 6,
   parameter int LAT_CONV   = 2,
   parameter int LAT_SIMPLE = 1,
   parameter int LAT_CMP    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   output logic             issue_valid,
   output logic [5:0]       issue_func,
   output logic [REG_W-1:0] issue_fs,
   output logic [REG_W-1:0] issue_ft,
   output logic [REG_W-1:0] issue_fd,
   output logic [3:0]       issue_lat,
   output logic             wb_valid,
   output logic [REG_W-1:0] wb_reg,
   output logic             wb_fcc,
   output logic             err
);
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
   localparam int NREG = 1 << REG_W;
   localparam int LMAX = max2(max2(max2(LAT_ADD, LAT_MUL), max2(LAT_INV, LAT_SQRT)),
                              max2(max2(LAT_CONV, LAT_SIMPLE), LAT_CMP));
   typedef struct packed {
      logic             v;
      logic             fcc;
      logic [REG_W-1:0] r;
   } slot_t;
   // ring_q[k] is the writeback that happens k cycles from now; slot 0 drives the port
   slot_t            ring_q [LMAX+1];
   slot_t            ring_d [LMAX+1];
   logic [NREG-1:0]  busy_q, busy_d;
   logic             fcc_busy_q, fcc_busy_d;
   logic             iv_q, err_q;
   logic [5:0]       func_q;
   logic [REG_W-1:0] fs_q, ft_q, fd_q;
   logic [3:0]       lat_q;
   logic [5:0]       op, funct;
   logic [REG_W-1:0] fs, ft, fd;
   logic             legal, two, cmp, port, hazard, accept, unused_fmt;
   logic [3:0]       lat;
   assign op         = in_inst[31:26];
   assign funct      = in_inst[5:0];
   assign ft         = REG_W'(in_inst[20:16]);
   assign fs         = REG_W'(in_inst[15:11]);
   assign fd         = REG_W'(in_inst[10:6]);
   assign unused_fmt = ^in_inst[25:21];
   always_comb begin
      legal = (op == 6'b010001);
      two   = 1'b0;
      cmp   = 1'b0;
      lat   = 4'd0;
      case (funct)
         6'h00, 6'h01:        begin two = 1'b1; lat = 4'(LAT_ADD); end
         6'h02:               begin two = 1'b1; lat = 4'(LAT_MUL); end
         6'h03:               lat = 4'(LAT_INV);
         6'h04:               lat = 4'(LAT_SQRT);
         6'h05, 6'h07:        lat = 4'(LAT_SIMPLE);
         6'h08, 6'h09:        lat = 4'(LAT_CONV);
         6'h32, 6'h34, 6'h36: begin two = 1'b1; cmp = 1'b1; lat = 4'(LAT_CMP); end
         default:             legal = 1'b0;
      endcase
   end
   always_comb begin
      port = 1'b0;
      for (int k = 1; k <= LMAX; k++)
         if (int'(lat) + 1 == k && ring_q[k].v) port = 1'b1;
      hazard   = legal && (busy_q[fs] || (two && busy_q[ft]) || (cmp ? fcc_busy_q : busy_q[fd]) || port);
      in_ready = !rst && !hazard;
      accept   = in_valid && in_ready;
   end
   always_comb begin
      busy_d     = busy_q;
      fcc_busy_d = fcc_busy_q;
      if (ring_q[0].v) begin
         if (ring_q[0].fcc) fcc_busy_d = 1'b0;
         else busy_d[ring_q[0].r] = 1'b0;
      end
      if (accept && legal) begin
         if (cmp) fcc_busy_d = 1'b1;
         else busy_d[fd] = 1'b1;
      end
      for (int k = 0; k < LMAX; k++) ring_d[k] = ring_q[k+1];
      ring_d[LMAX] = '0;
      for (int k = 0; k <= LMAX; k++)
         if (accept && legal && int'(lat) == k) ring_d[k] = '{v: 1'b1, fcc: cmp, r: fd};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= '0;
         fcc_busy_q <= 1'b0;
         iv_q       <= 1'b0;
         err_q      <= 1'b0;
         func_q     <= '0;
         fs_q       <= '0;
         ft_q       <= '0;
         fd_q       <= '0;
         lat_q      <= '0;
         for (int k = 0; k <= LMAX; k++) ring_q[k] <= '0;
      end else begin
         busy_q     <= busy_d;
         fcc_busy_q <= fcc_busy_d;
         ring_q     <= ring_d;
         iv_q       <= accept && legal;
         err_q      <= accept && !legal;
         if (accept && legal) begin
            func_q <= funct;
            fs_q   <= fs;
            ft_q   <= ft;
            fd_q   <= fd;
            lat_q  <= lat;
         end
      end
   end
   assign issue_valid = iv_q && !rst;
   assign issue_func  = func_q;
   assign issue_fs    = fs_q;
   assign issue_ft    = ft_q;
   assign issue_fd    = fd_q;
   assign issue_lat   = lat_q;
   assign err         = err_q && !rst;
   assign wb_valid    = ring_q[0].v && !rst;
   assign wb_reg      = ring_q[0].r;
   assign wb_fcc      = ring_q[0].fcc;
endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// tb_fpu_issue_scoreboard: directed scenarios plus random traffic against a cycle-stamped scoreboard model.
module tb_fpu_issue_scoreboard;
   localparam logic [5:0] FPU = 6'b010001;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, issue_valid, wb_valid, wb_fcc, err;
   logic [31:0] in_inst;
   logic [5:0]  issue_func;
   logic [4:0]  issue_fs, issue_ft, issue_fd, wb_reg;
   logic [3:0]  issue_lat;
   int          total = 0, bad = 0, cyc = 0;
   int          bu [32];
   int          fu;
   int          wb_at [int];
   bit          pi_v, pe, pcmp;
   logic [5:0]  pf;
   logic [4:0]  pfs, pft, pfd;
   int          pl;
   logic        s_ready, s_iv, s_wb, s_wbf, s_err;
   logic [4:0]  s_fd, s_wbr;
   logic [3:0]  s_lat;

   fpu_issue_scoreboard dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .issue_valid(issue_valid), .issue_func(issue_func), .issue_fs(issue_fs), .issue_ft(issue_ft),
      .issue_fd(issue_fd), .issue_lat(issue_lat), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .wb_fcc(wb_fcc), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", n, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] ft, input logic [4:0] fs,
                                      input logic [4:0] fd, input logic [5:0] fn);
      return {op, 5'd0, ft, fs, fd, fn};
   endfunction

   function automatic void dec(input logic [31:0] i, output bit lg, output int l, output bit tw, output bit cp);
      lg = 1; l = 0; tw = 0; cp = 0;
      case (i[5:0])
         6'h00, 6'h01:        begin l = 3; tw = 1; end
         6'h02:               begin l = 2; tw = 1; end
         6'h03, 6'h04:        l = 6;
         6'h05, 6'h07:        l = 1;
         6'h08, 6'h09:        l = 2;
         6'h32, 6'h34, 6'h36: begin l = 1; tw = 1; cp = 1; end
         default:             lg = 0;
      endcase
      if (i[31:26] != FPU) lg = 0;
   endfunction

   // one clock: drive, check everything against the model mid-cycle, then advance the model
   task automatic step(input bit v, input logic [31:0] inst, input bit r);
      bit lg, tw, cp, er, ew;
      int l, e;
      logic [4:0] fs, ft, fd;
      in_valid = v; in_inst = inst; rst = r;
      @(negedge clk);
      s_ready = in_ready; s_iv = issue_valid; s_fd = issue_fd; s_lat = issue_lat;
      s_wb = wb_valid; s_wbr = wb_reg; s_wbf = wb_fcc; s_err = err;
      dec(inst, lg, l, tw, cp);
      ft = inst[20:16]; fs = inst[15:11]; fd = inst[10:6];
      er = !r && !(lg && (bu[fs] >= cyc || (tw && bu[ft] >= cyc) || (cp ? fu >= cyc : bu[fd] >= cyc)
                          || wb_at.exists(cyc + 1 + l)));
      chk("in_ready", in_ready, er);
      chk("issue_valid", issue_valid, !r && pi_v);
      if (!r && pi_v) begin
         chk("issue_func", issue_func, pf);
         chk("issue_fs", issue_fs, pfs);
         chk("issue_ft", issue_ft, pft);
         chk("issue_lat", issue_lat, pl);
         if (!pcmp) chk("issue_fd", issue_fd, pfd);
      end
      chk("err", err, !r && pe);
      ew = !r && wb_at.exists(cyc);
      chk("wb_valid", wb_valid, ew);
      if (ew) begin
         e = wb_at[cyc];
         chk("wb_fcc", wb_fcc, e[8]);
         if (!e[8]) chk("wb_reg", wb_reg, e[4:0]);
      end
      pi_v = 0; pe = 0;
      if (r) begin
         foreach (bu[i]) bu[i] = -1;
         fu = -1;
         wb_at.delete();
      end else if (v && er) begin
         if (lg) begin
            pi_v = 1; pf = inst[5:0]; pfs = fs; pft = ft; pfd = fd; pl = l; pcmp = cp;
            if (cp) fu = cyc + 1 + l;
            else bu[fd] = cyc + 1 + l;
            wb_at[cyc + 1 + l] = (cp ? 256 : 0) + int'(fd);
         end else pe = 1;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 32'd0, 0);
   endtask

   initial begin
      logic [5:0] fl [13] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09,
                              6'h32, 6'h34, 6'h36, 6'h3f};
      logic [31:0] add7, mul, ceq;
      rst = 1; in_valid = 0; in_inst = 0; fu = -1;
      foreach (bu[i]) bu[i] = -1;
      repeat (2) @(posedge clk);
      #1;
      // simple add: issue next cycle, writeback three cycles later
      step(0, 32'd0, 1);
      step(1, mk(FPU, 2, 1, 3, 6'h00), 0); chk("s1_ready", s_ready, 1);
      step(0, 32'd0, 0); chk("s1_iv", s_iv, 1); chk("s1_fd", s_fd, 3); chk("s1_lat", s_lat, 3);
      idle(2);
      step(0, 32'd0, 0); chk("s1_wb", s_wb, 1); chk("s1_wbr", s_wbr, 3);
      // RAW stall until the cycle after writeback
      step(0, 32'd0, 1);
      mul = mk(FPU, 5, 3, 4, 6'h02);
      step(1, mk(FPU, 2, 1, 3, 6'h00), 0);
      for (int i = 1; i <= 5; i++) begin
         step(1, mul, 0); chk("s2_ready", s_ready, i == 5);
      end
      idle(2);
      step(0, 32'd0, 0); chk("s2_wb", s_wb, 1); chk("s2_wbr", s_wbr, 4);
      // writeback port conflict
      step(0, 32'd0, 1);
      add7 = mk(FPU, 2, 1, 7, 6'h00);
      step(1, mk(FPU, 0, 1, 6, 6'h03), 0);
      idle(2);
      step(1, add7, 0); chk("s3_port", s_ready, 0);
      step(1, add7, 0); chk("s3_ready", s_ready, 1);
      idle(2);
      step(0, 32'd0, 0); chk("s3_wb6", s_wbr, 6);
      step(0, 32'd0, 0); chk("s3_wb7", s_wbr, 7);
      // illegal instructions
      step(0, 32'd0, 1);
      step(1, mk(6'b100011, 2, 1, 3, 6'h00), 0); chk("s4_ready_lw", s_ready, 1);
      step(1, mk(FPU, 2, 1, 3, 6'h3f), 0); chk("s4_ready_fn", s_ready, 1); chk("s4_err1", s_err, 1);
      step(0, 32'd0, 0); chk("s4_err2", s_err, 1); chk("s4_iv", s_iv, 0);
      step(0, 32'd0, 0); chk("s4_err_done", s_err, 0);
      // FCC WAW between compares
      step(0, 32'd0, 1);
      ceq = mk(FPU, 2, 1, 0, 6'h32);
      step(1, mk(FPU, 2, 1, 0, 6'h34), 0); chk("s5_ready_lt", s_ready, 1);
      step(1, ceq, 0); chk("s5_stall1", s_ready, 0);
      step(1, ceq, 0); chk("s5_stall2", s_ready, 0); chk("s5_wbf", s_wbf, 1);
      step(1, ceq, 0); chk("s5_ready_eq", s_ready, 1);
      // reset discards an in-flight sqrt
      step(0, 32'd0, 1);
      step(1, mk(FPU, 0, 1, 9, 6'h04), 0);
      idle(2);
      step(0, 32'd0, 1); chk("s6_wb_rst", s_wb, 0);
      step(0, mk(FPU, 0, 9, 10, 6'h05), 0); chk("s6_ready", s_ready, 1); chk("s6_wb4", s_wb, 0);
      for (int i = 5; i <= 10; i++) begin
         idle(1); chk("s6_nowb", s_wb, 0);
      end
      // random traffic on a small register window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 15) == 0) ? 6'b100011 : FPU;
         step($urandom_range(0, 9) < 7,
              mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 fl[$urandom_range(0, 12)]),
              $urandom_range(0, 199) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
